cave_input_ctrl: RTL and testbench
==================================

// Module: cave_input_ctrl
// PURPOSE
// Input conditioning stage feeding the Main player ports. Merges PS/2 key events and
// HPS joystick words into the two 9-bit player vectors and the pause level. Adds
// coin pulse shaping, pause toggling and opposing-direction cleaning. All outputs registered.
// PARAMETERS
// COIN_CYCLES  1_000_000  coin output high time in clk_sys cycles (10 ms at 100 MHz); >=1
// SOCD_CLEAN   1          1: up+down or left+right held together -> both pair bits forced 0
// PORTS
// clk_sys     in   1   system clock (100 MHz)
// reset_n     in   1   asynchronous active-low reset
// ps2_key     in   11  [10] event toggle, [9] pressed, [7:0] scan code
// joystick_0  in   10  P1 pad: [0]R [1]L [2]D [3]U [4]B1 [5]B2 [6]B3 [7]Start [8]Coin [9]Pause
// joystick_1  in   10  P2 pad, same layout
// player_1    out  9   {coin,start,b3,b2,b1,right,left,down,up} to Main io_player_player1
// player_2    out  9   same layout, to io_player_player2
// pause       out  1   pause level to Main io_player_pause
// BEHAVIOUR
// - Reset (reset_n=0, async): all key regs, old_toggle, primed, coin counters, pause,
//   player_1, player_2 -> 0. Release is synchronised internally (2-flop) before use.
// - primed=0 after reset: first clock loads old_toggle<=ps2_key[10], sets primed, decodes nothing.
// - Key event: primed && ps2_key[10]!=old_toggle at edge N -> old_toggle updated, matching key
//   reg <= ps2_key[9] at edge N; unknown codes update only old_toggle. Extended prefix ignored.
// - Scan codes: P1 75 U, 72 D, 6B L, 74 R, 14 B1, 11 B2, 29 B3, 16 Start, 2E Coin, 4D Pause;
//   P2 2D U, 2B D, 23 L, 34 R, 1C B1, 1B B2, 15 B3, 1E Start, 36 Coin.
// - Raw source per bit = key reg OR joystick bit; joystick words sampled every clock.
// - Latency: key reg change at edge N -> player/pause output at edge N+1; joystick change
//   sampled at edge N -> output at edge N+1.
// - SOCD (per player, SOCD_CLEAN=1): raw U&D -> up=down=0; raw L&R -> left=right=0. No memory
//   of press order. SOCD_CLEAN=0: pass through.
// - Coin FSM per player, states IDLE/PULSE/WAIT_REL:
//   IDLE: raw coin rising edge (raw=1, prev raw=0) -> PULSE, cnt<=COIN_CYCLES-1, coin out=1.
//   PULSE: cnt decrements each clock; coin out=1; at cnt==0 -> WAIT_REL if raw=1 else IDLE.
//   WAIT_REL: coin out=0; raw=0 -> IDLE. Presses during PULSE/WAIT_REL are ignored (no queue).
//   Exactly COIN_CYCLES high cycles per accepted edge; cnt width $clog2(COIN_CYCLES+1).
// - Pause: rising edge of (key_p | joystick_0[9] | joystick_1[9]) toggles pause reg, output
//   next edge. Simultaneous edges on several sources = one toggle. Held input = no repeat.
// - Simultaneous key event and joystick change: both take effect, outputs reflect OR.
// - reset_n asserted mid coin pulse: output drops immediately, FSM IDLE; held coin after
//   release does not produce a pulse until released and pressed again (prev raw captured at 1).
// TESTING
// 1 Reset then toggle ps2_key[10] with {pressed=1,code=75} -> player_1[0]=1 one clock later;
//   release event -> 0; unknown code 0x5A -> no output bit changes.
// 2 joystick_0[3] and [2] both 1, SOCD_CLEAN=1 -> player_1[1:0]=00; drop [2] -> 01 next clock.
// 3 COIN_CYCLES=8: hold joystick_1[8] 100 clocks -> player_2[8] high exactly 8 clocks, one pulse;
//   release+press at clock 3 of pulse -> ignored; press after release post-pulse -> new pulse.
// 4 key 4D press, release, press -> pause 0->1->1->0; joystick_0[9] and key_p rising same clock
//   -> single toggle.
// 5 First clock after reset with ps2_key[10]=1 -> no decode; next toggle decodes normally.
// 6 Assert reset_n=0 on pulse clock 4 -> player_1[8]=0 asynchronously; release with coin held
//   -> no pulse until coin low then high.

Source files
------------

// File: rtl/cave_input_ctrl.sv
// -----------------------------------------------------------------------------
// cave_input_ctrl
// Input conditioning ahead of the Main player ports. PS/2 key events and HPS
// joystick words are merged into two 9-bit player vectors plus a pause level.
// Coin inputs are shaped into fixed-length pulses, pause is a toggle, and
// opposing directions held together are cleaned to neutral.
//
// Ports
//   clk_sys     in   1   system clock
//   reset_n     in   1   asynchronous active-low reset (release synchronised)
//   ps2_key     in   11  [10] event toggle, [9] pressed, [7:0] scan code
//   joystick_0  in   10  P1 pad {pause,coin,start,b3,b2,b1,up,down,left,right}
//   joystick_1  in   10  P2 pad, same layout
//   player_1    out  9   {coin,start,b3,b2,b1,right,left,down,up}
//   player_2    out  9   same layout
//   pause       out  1   pause level
// -----------------------------------------------------------------------------
module cave_input_ctrl #(
    parameter int COIN_CYCLES = 1_000_000,
    parameter bit SOCD_CLEAN  = 1'b1
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [9:0]  joystick_0,
    input  logic [9:0]  joystick_1,
    output logic [8:0]  player_1,
    output logic [8:0]  player_2,
    output logic        pause
);

    localparam int             CW       = $clog2(COIN_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(COIN_CYCLES - 1);

    typedef enum logic [1:0] {C_IDLE, C_PULSE, C_WAIT} coin_st_t;

    // ------------------------------------------------------------------
    // Reset: asserts asynchronously, releases two clocks later.
    // ------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // Joystick sample flops carry no reset so that a button held through
    // reset is already visible when edge history is primed; otherwise a held
    // coin would fire a pulse right after release.
    logic [9:0] r_joy0, r_joy1;
    always_ff @(posedge clk_sys) begin
        r_joy0 <= joystick_0;
        r_joy1 <= joystick_1;
    end

    // ps2_key[8] is the extended-prefix flag; it is deliberately ignored.
    logic w_unused;
    assign w_unused = ps2_key[8];

    // ------------------------------------------------------------------
    // PS/2 key decode. Key regs use the player bit layout.
    // ------------------------------------------------------------------
    logic       r_old_toggle, r_primed;
    logic [8:0] r_key1, r_key2;
    logic       r_key_p;

    always_ff @(posedge clk_sys or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_old_toggle <= 1'b0;
            r_primed     <= 1'b0;
            r_key1       <= '0;
            r_key2       <= '0;
            r_key_p      <= 1'b0;
        end else if (!r_primed) begin
            // first clock only adopts the current toggle phase
            r_old_toggle <= ps2_key[10];
            r_primed     <= 1'b1;
        end else if (ps2_key[10] != r_old_toggle) begin
            r_old_toggle <= ps2_key[10];
            case (ps2_key[7:0])
                8'h75: r_key1[0] <= ps2_key[9];
                8'h72: r_key1[1] <= ps2_key[9];
                8'h6B: r_key1[2] <= ps2_key[9];
                8'h74: r_key1[3] <= ps2_key[9];
                8'h14: r_key1[4] <= ps2_key[9];
                8'h11: r_key1[5] <= ps2_key[9];
                8'h29: r_key1[6] <= ps2_key[9];
                8'h16: r_key1[7] <= ps2_key[9];
                8'h2E: r_key1[8] <= ps2_key[9];
                8'h4D: r_key_p   <= ps2_key[9];
                8'h2D: r_key2[0] <= ps2_key[9];
                8'h2B: r_key2[1] <= ps2_key[9];
                8'h23: r_key2[2] <= ps2_key[9];
                8'h34: r_key2[3] <= ps2_key[9];
                8'h1C: r_key2[4] <= ps2_key[9];
                8'h1B: r_key2[5] <= ps2_key[9];
                8'h15: r_key2[6] <= ps2_key[9];
                8'h1E: r_key2[7] <= ps2_key[9];
                8'h36: r_key2[8] <= ps2_key[9];
                default: ;
            endcase
        end
    end

    // Pad order {coin,start,b3,b2,b1,U,D,L,R} -> player order {..,R,L,D,U}
    function automatic logic [8:0] joy_map(input logic [8:0] j);
        return {j[8], j[7], j[6], j[5], j[4], j[0], j[1], j[2], j[3]};
    endfunction

    function automatic logic [7:0] socd(input logic [7:0] r);
        logic [7:0] o;
        o = r;
        if (SOCD_CLEAN) begin
            if (r[0] && r[1]) o[1:0] = 2'b00;
            if (r[2] && r[3]) o[3:2] = 2'b00;
        end
        return o;
    endfunction

    logic [8:0] w_raw1, w_raw2;
    logic [1:0] w_coin_raw;
    logic       w_pause_src;

    assign w_raw1      = r_key1 | joy_map(r_joy0[8:0]);
    assign w_raw2      = r_key2 | joy_map(r_joy1[8:0]);
    assign w_coin_raw  = {w_raw2[8], w_raw1[8]};
    assign w_pause_src = r_key_p | r_joy0[9] | r_joy1[9];

    // ------------------------------------------------------------------
    // Output stage: directions/buttons, coin pulse FSMs, pause toggle.
    // Edge detection is held off until r_primed so history is captured
    // from live inputs first.
    // ------------------------------------------------------------------
    coin_st_t      r_cst [2];
    logic [CW-1:0] r_cnt [2];
    logic [1:0]    r_coin_out, r_coin_prev;
    logic          r_pause_prev, r_pause;
    logic [7:0]    r_p1_lo, r_p2_lo;

    always_ff @(posedge clk_sys or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int p = 0; p < 2; p++) begin
                r_cst[p] <= C_IDLE;
                r_cnt[p] <= '0;
            end
            r_coin_out   <= '0;
            r_coin_prev  <= '0;
            r_pause_prev <= 1'b0;
            r_pause      <= 1'b0;
            r_p1_lo      <= '0;
            r_p2_lo      <= '0;
        end else begin
            r_p1_lo      <= socd(w_raw1[7:0]);
            r_p2_lo      <= socd(w_raw2[7:0]);
            r_coin_prev  <= w_coin_raw;
            r_pause_prev <= w_pause_src;

            if (r_primed && w_pause_src && !r_pause_prev)
                r_pause <= ~r_pause;

            for (int p = 0; p < 2; p++) begin
                case (r_cst[p])
                    C_IDLE: begin
                        if (r_primed && w_coin_raw[p] && !r_coin_prev[p]) begin
                            r_cst[p]      <= C_PULSE;
                            r_cnt[p]      <= CNT_LOAD;
                            r_coin_out[p] <= 1'b1;
                        end
                    end
                    C_PULSE: begin
                        if (r_cnt[p] == '0) begin
                            r_coin_out[p] <= 1'b0;
                            r_cst[p]      <= w_coin_raw[p] ? C_WAIT : C_IDLE;
                        end else begin
                            r_cnt[p] <= r_cnt[p] - 1'b1;
                        end
                    end
                    C_WAIT: begin
                        if (!w_coin_raw[p]) r_cst[p] <= C_IDLE;
                    end
                    default: r_cst[p] <= C_IDLE;
                endcase
            end
        end
    end

    assign player_1 = {r_coin_out[0], r_p1_lo};
    assign player_2 = {r_coin_out[1], r_p2_lo};
    assign pause    = r_pause;

endmodule

// File: tb/tb_cave_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cave_input_ctrl
// Directed stimulus with hand-computed expectations. Each expectation is
// stamped with the clock cycle at which it must hold and queued; a monitor
// on the falling edge pops and compares the full {pause,player_2,player_1}.
// -----------------------------------------------------------------------------
module tb_cave_input_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [9:0]  joystick_0, joystick_1;
    logic [8:0]  player_1, player_2;
    logic        pause;

    cave_input_ctrl #(.COIN_CYCLES(8), .SOCD_CLEAN(1'b1)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_key    (ps2_key),
        .joystick_0 (joystick_0),
        .joystick_1 (joystick_1),
        .player_1   (player_1),
        .player_2   (player_2),
        .pause      (pause)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int          cyc;
        string       name;
        logic [18:0] val;   // {pause, player_2, player_1}
    } exp_t;

    exp_t sb[$];
    int   cyc_cnt  = 0;
    int   checks   = 0;
    int   failures = 0;

    always @(posedge clk_sys) cyc_cnt <= cyc_cnt + 1;

    // monitor
    exp_t e;
    always @(negedge clk_sys) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            e = sb.pop_front();
            checks++;
            if ({pause, player_2, player_1} !== e.val) begin
                failures++;
                $display("FAIL %s cyc=%0d got p1=%h p2=%h pause=%b want p1=%h p2=%h pause=%b",
                         e.name, cyc_cnt, player_1, player_2, pause,
                         e.val[8:0], e.val[17:9], e.val[18]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic exp_rng(input int d0, input int d1, input string nm,
                           input logic [8:0] p1, input logic [8:0] p2, input logic ps);
        exp_t x;
        for (int d = d0; d <= d1; d++) begin
            x.cyc  = cyc_cnt + d;
            x.name = nm;
            x.val  = {ps, p2, p1};
            sb.push_back(x);
        end
    endtask

    // inputs were just driven: expect new value from 2 cycles on, hold n cycles
    task automatic step(input int n, input string nm,
                        input logic [8:0] p1, input logic [8:0] p2, input logic ps);
        exp_rng(2, n + 1, nm, p1, p2, ps);
        tick(n);
    endtask

    task automatic key_ev(input logic pr, input logic [7:0] code);
        ps2_key = {~ps2_key[10], pr, 1'b0, code};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        ps2_key    = {1'b1, 1'b1, 1'b0, 8'h75};  // toggle high before priming
        joystick_0 = '0;
        joystick_1 = '0;
        #1;
        exp_rng(0, 3, "reset", 9'h0, 9'h0, 1'b0);
        tick(3);

        // priming clock must not decode the pending toggle
        reset_n = 1'b1;
        step(6, "prime_no_decode", 9'h0, 9'h0, 1'b0);

        // key decode
        key_ev(1'b1, 8'h75); step(4, "key_up_press",   9'h001, 9'h0, 1'b0);
        key_ev(1'b1, 8'h5A); step(4, "unknown_code",   9'h001, 9'h0, 1'b0);
        key_ev(1'b0, 8'h75); step(4, "key_up_release", 9'h000, 9'h0, 1'b0);
        key_ev(1'b1, 8'h74); step(4, "key_right",      9'h008, 9'h0, 1'b0);
        key_ev(1'b1, 8'h16); step(4, "key_start",      9'h088, 9'h0, 1'b0);
        key_ev(1'b0, 8'h74); step(4, "key_right_rel",  9'h080, 9'h0, 1'b0);
        key_ev(1'b0, 8'h16); step(4, "key_start_rel",  9'h000, 9'h0, 1'b0);

        // key and joystick together are ORed
        key_ev(1'b1, 8'h1C); joystick_1 = 10'h020;
        step(4, "key_joy_or", 9'h0, 9'h030, 1'b0);
        key_ev(1'b0, 8'h1C); joystick_1 = 10'h000;
        step(4, "key_joy_clear", 9'h0, 9'h000, 1'b0);

        // SOCD cleaning
        joystick_0 = 10'b00_0000_1100; step(4, "socd_ud",     9'h000, 9'h0, 1'b0);
        joystick_0 = 10'b00_0000_1000; step(4, "socd_drop_d", 9'h001, 9'h0, 1'b0);
        joystick_0 = 10'b00_0001_0011; step(4, "socd_lr",     9'h010, 9'h0, 1'b0);
        joystick_0 = 10'b00_0000_0001; step(4, "right_only",  9'h008, 9'h0, 1'b0);
        joystick_0 = 10'h000;          step(4, "joy_idle",    9'h000, 9'h0, 1'b0);
        key_ev(1'b1, 8'h2D); step(4, "p2_up",    9'h0, 9'h001, 1'b0);
        key_ev(1'b1, 8'h2B); step(4, "p2_socd",  9'h0, 9'h000, 1'b0);
        key_ev(1'b0, 8'h2D); step(4, "p2_down",  9'h0, 9'h002, 1'b0);
        key_ev(1'b0, 8'h2B); step(4, "p2_clear", 9'h0, 9'h000, 1'b0);

        // coin held 100 clocks: one 8-cycle pulse
        joystick_1 = 10'h100;
        exp_rng(2, 9,   "coin_pulse", 9'h0, 9'h100, 1'b0);
        exp_rng(10, 101, "coin_held", 9'h0, 9'h000, 1'b0);
        tick(100);
        joystick_1 = 10'h000; step(5, "coin_rel", 9'h0, 9'h0, 1'b0);

        // release + re-press during pulse is ignored
        joystick_1 = 10'h100;
        exp_rng(2, 9,  "coin_pulse2",     9'h0, 9'h100, 1'b0);
        exp_rng(10, 21, "coin_no_requeue", 9'h0, 9'h000, 1'b0);
        tick(2);
        joystick_1 = 10'h000;
        tick(2);
        joystick_1 = 10'h100;
        tick(16);
        joystick_1 = 10'h000; step(5, "coin_wait_rel", 9'h0, 9'h0, 1'b0);
        joystick_1 = 10'h100;
        exp_rng(2, 9,  "coin_repress", 9'h0, 9'h100, 1'b0);
        exp_rng(10, 10, "coin_end",    9'h0, 9'h000, 1'b0);
        tick(9);
        joystick_1 = 10'h000; step(4, "coin_idle", 9'h0, 9'h0, 1'b0);

        // pause toggling
        key_ev(1'b1, 8'h4D); step(4, "pause_on",   9'h0, 9'h0, 1'b1);
        key_ev(1'b0, 8'h4D); step(4, "pause_hold", 9'h0, 9'h0, 1'b1);
        key_ev(1'b1, 8'h4D); step(4, "pause_off",  9'h0, 9'h0, 1'b0);
        key_ev(1'b0, 8'h4D); step(4, "pause_rel",  9'h0, 9'h0, 1'b0);
        key_ev(1'b1, 8'h4D); joystick_0 = 10'h200;
        step(10, "pause_simul", 9'h0, 9'h0, 1'b1);
        key_ev(1'b0, 8'h4D); joystick_0 = 10'h000;
        step(4, "pause_rel2", 9'h0, 9'h0, 1'b1);
        joystick_1 = 10'h200; step(4, "pause_p2",     9'h0, 9'h0, 1'b0);
        joystick_1 = 10'h000; step(4, "pause_p2_rel", 9'h0, 9'h0, 1'b0);
        joystick_1 = 10'h200; step(4, "pause_p2_on",  9'h0, 9'h0, 1'b1);
        joystick_1 = 10'h000; step(4, "pause_p2_r2",  9'h0, 9'h0, 1'b1);

        // reset asserted on the 4th pulse clock drops outputs at once
        joystick_0 = 10'h100;
        exp_rng(2, 4, "coin_p1", 9'h100, 9'h0, 1'b1);
        tick(5);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({pause, player_2, player_1} !== 19'h0) begin
            failures++;
            $display("FAIL async_reset got p1=%h p2=%h pause=%b want all zero",
                     player_1, player_2, pause);
        end
        exp_rng(0, 3, "rst_hold", 9'h0, 9'h0, 1'b0);
        tick(3);
        reset_n = 1'b1;
        step(20, "held_after_rst", 9'h0, 9'h0, 1'b0);
        joystick_0 = 10'h000; step(4, "coin_low", 9'h0, 9'h0, 1'b0);
        joystick_0 = 10'h100;
        exp_rng(2, 9,  "coin_after_rst", 9'h100, 9'h0, 1'b0);
        exp_rng(10, 10, "coin_after_end", 9'h000, 9'h0, 1'b0);
        tick(9);
        joystick_0 = 10'h000; step(4, "final_idle", 9'h0, 9'h0, 1'b0);

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk_sys);
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
